// File: rtl/fpadd_ctrl.sv
// Multi-cycle IEEE-754 single-precision adder with valid/ready handshakes.
// Optional flags port {ovf, zero, nan} is enabled by defining FPADD_FLAGS_EN.
module fpadd_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_input,
  input  logic [31:0] b_input,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic        busy
`ifdef FPADD_FLAGS_EN
  ,
  output logic [2:0]  flags
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_ALIGN  = 3'd2,
    S_ADD    = 3'd3,
    S_NORM   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [7:0]  ea_q, ea_d;
  logic [7:0]  eb_q, eb_d;
  logic [24:0] ma_q, ma_d;
  logic [23:0] mb_q, mb_d;
  logic [31:0] sum_q, sum_d;

  logic        accept_s;
  logic        a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
  logic        special_s;
  logic [31:0] special_res_s;
  logic        swap_s;
  logic [31:0] big_s, small_s;
  logic [7:0]  diff_s;
  logic [23:0] mb_shift_s;
  logic [7:0]  ea_inc_s, ea_dec_s;

  assign in_ready  = (state_q == S_IDLE) & ~rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign sum       = sum_q;
  assign accept_s  = in_valid & in_ready;

  assign a_nan_s  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan_s  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
  assign a_inf_s  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf_s  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_zero_s = (a_q[30:23] == 8'd0);
  assign b_zero_s = (b_q[30:23] == 8'd0);

  // Comparing exponent:fraction as one field orders by exponent, then magnitude.
  assign swap_s  = (a_q[30:0] < b_q[30:0]);
  assign big_s   = swap_s ? b_q : a_q;
  assign small_s = swap_s ? a_q : b_q;

  assign diff_s     = ea_q - eb_q;
  assign mb_shift_s = (diff_s >= 8'd25) ? 24'd0 : (mb_q >> diff_s);
  assign ea_inc_s   = ea_q + 8'd1;
  assign ea_dec_s   = ea_q - 8'd1;

  // Special-operand result selection for the UNPACK fast path.
  always_comb begin
    special_s     = 1'b1;
    special_res_s = 32'd0;
    if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (a_q[31] != b_q[31]))) begin
      special_res_s = 32'h7FC0_0000;
    end else if (a_inf_s) begin
      special_res_s = a_q;
    end else if (b_inf_s) begin
      special_res_s = b_q;
    end else if (a_zero_s && b_zero_s) begin
      special_res_s = {a_q[31] & b_q[31], 31'd0};
    end else if (a_zero_s) begin
      special_res_s = b_q;
    end else if (b_zero_s) begin
      special_res_s = a_q;
    end else begin
      special_s     = 1'b0;
      special_res_s = 32'd0;
    end
  end

  // Next-state and datapath update for every FSM state.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ea_d    = ea_q;
    eb_d    = eb_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    sum_d   = sum_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          a_d     = a_input;
          b_d     = b_input;
          state_d = S_UNPACK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_UNPACK: begin
        if (special_s) begin
          sum_d   = special_res_s;
          state_d = S_DONE;
        end else begin
          sa_d    = big_s[31];
          sb_d    = small_s[31];
          ea_d    = big_s[30:23];
          eb_d    = small_s[30:23];
          ma_d    = {2'b01, big_s[22:0]};
          mb_d    = {1'b1, small_s[22:0]};
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        mb_d    = mb_shift_s;
        state_d = S_ADD;
      end
      S_ADD: begin
        if (sa_q == sb_q) begin
          ma_d = ma_q + {1'b0, mb_q};
        end else begin
          ma_d = ma_q - {1'b0, mb_q};
        end
        state_d = S_NORM;
      end
      S_NORM: begin
        if (ma_q == 25'd0) begin
          sum_d   = 32'd0;
          state_d = S_DONE;
        end else if (ma_q[24]) begin
          if (ea_q == 8'd254) begin
            sum_d = {sa_q, 8'hFF, 23'd0};
          end else begin
            sum_d = {sa_q, ea_inc_s, ma_q[23:1]};
          end
          state_d = S_DONE;
        end else if (ma_q[23]) begin
          sum_d   = {sa_q, ea_q, ma_q[22:0]};
          state_d = S_DONE;
        end else if (ea_q == 8'd1) begin
          // The next left shift would land on exponent 0: flush to signed zero.
          sum_d   = {sa_q, 31'd0};
          state_d = S_DONE;
        end else begin
          ma_d    = {ma_q[23:0], 1'b0};
          ea_d    = ea_dec_s;
          state_d = S_NORM;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      ea_q    <= 8'd0;
      eb_q    <= 8'd0;
      ma_q    <= 25'd0;
      mb_q    <= 24'd0;
      sum_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      sum_q   <= sum_d;
    end
  end

`ifdef FPADD_FLAGS_EN
  logic [2:0] flags_q, flags_d;
  logic       ovf_s;

  assign ovf_s = (state_q == S_NORM) && ma_q[24] && (ea_q == 8'd254);
  assign flags = flags_q;

  // Capture flags together with the result on entry to DONE.
  always_comb begin
    flags_d = flags_q;
    if ((state_q != S_DONE) && (state_d == S_DONE)) begin
      flags_d = {ovf_s,
                 (sum_d[30:0] == 31'd0),
                 (sum_d[30:23] == 8'hFF) && (sum_d[22:0] != 23'd0)};
    end else begin
      flags_d = flags_q;
    end
  end

  // Flags register.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 3'd0;
    end else begin
      flags_q <= flags_d;
    end
  end
`endif

endmodule

// File: tb/tb_fpadd_ctrl.sv
// Self-checking bench for fpadd_ctrl: directed vectors, a behavioural float-add
// model, and a per-cycle compare process on the falling clock edge.
module tb_fpadd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_input = 32'd0;
  logic [31:0] b_input = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sum;
  logic        busy;
`ifdef FPADD_FLAGS_EN
  logic [2:0]  flags;
  logic [2:0]  exp_flags = 3'd0;
`endif

  fpadd_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_input   (a_input),
    .b_input   (b_input),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .busy      (busy)
`ifdef FPADD_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic        pending = 1'b0;
  logic        in_reset = 1'b1;
  int          accept_cyc = 0;
  logic [31:0] exp_sum = 32'd0;
  int          exp_lat = 0;
  logic        exp_ovf = 1'b0;
  logic [31:0] last_sum = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
  endtask

  // Float add from the rules: specials, truncating alignment, normalisation.
  function automatic void fp_model(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] s, output int lat, output logic ovf);
    logic an, bn, ai, bi, az, bz, fin;
    logic [31:0] hi, lo;
    int e, d, norm;
    longint ma, mb, r;
    ovf = 1'b0; lat = 1; s = 32'd0;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    az = (a[30:23] == 8'd0);
    bz = (b[30:23] == 8'd0);
    if (an || bn || (ai && bi && (a[31] != b[31]))) s = 32'h7FC00000;
    else if (ai) s = a;
    else if (bi) s = b;
    else if (az && bz) s = {a[31] & b[31], 31'd0};
    else if (az) s = b;
    else if (bz) s = a;
    else begin
      if (a[30:0] >= b[30:0]) begin hi = a; lo = b; end
      else begin hi = b; lo = a; end
      e  = int'(hi[30:23]);
      d  = e - int'(lo[30:23]);
      ma = 64'h800000 + longint'(hi[22:0]);
      mb = 64'h800000 + longint'(lo[22:0]);
      mb = (d >= 25) ? 64'd0 : (mb >> d);
      r  = (hi[31] == lo[31]) ? (ma + mb) : (ma - mb);
      norm = 0;
      fin = 1'b0;
      for (int i = 0; i < 30 && !fin; i++) begin
        norm++;
        fin = 1'b1;
        if (r == 0) s = 32'd0;
        else if (r >= 64'h1000000) begin
          r = r >> 1;
          e = e + 1;
          if (e == 255) begin s = {hi[31], 8'hFF, 23'd0}; ovf = 1'b1; end
          else s = {hi[31], 8'(e), 23'(r)};
        end else if (r >= 64'h800000) s = {hi[31], 8'(e), 23'(r)};
        else begin
          r = r << 1;
          e = e - 1;
          if (e == 0) s = {hi[31], 31'd0};
          else fin = 1'b0;
        end
      end
      lat = 3 + norm;
    end
  endfunction

  // Per-cycle comparison of every output against the model state.
  always @(negedge clk) begin
    if (!in_reset) begin
      if (pending) begin
        logic ev;
        ev = ((cyc - accept_cyc) >= exp_lat);
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("busy_active", 32'(busy), 32'd1);
        chk("in_ready_active", 32'(in_ready), 32'd0);
        chk("sum", sum, ev ? exp_sum : last_sum);
        if (ev && exp_ovf) chk("ovf_is_inf", {1'b0, sum[30:0]}, 32'h7F800000);
`ifdef FPADD_FLAGS_EN
        if (ev) chk("flags", 32'(flags), 32'(exp_flags));
`endif
      end else begin
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_sum_held", sum, last_sum);
      end
    end
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s; int l; logic o;
    in_valid = 1'b1; a_input = a; b_input = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    fp_model(a, b, s, l, o);
    exp_sum = s; exp_lat = l; exp_ovf = o;
`ifdef FPADD_FLAGS_EN
    exp_flags = {o, s[30:0] == 31'd0, (s[30:23] == 8'hFF) && (s[22:0] != 23'd0)};
`endif
    accept_cyc = cyc;
    pending = 1'b1;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    int n;
    start_op(a, b);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (!out_valid) chk("result_timeout", 32'(out_valid), 32'd1);
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    pending = 1'b0;
    last_sum = exp_sum;
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef FPADD_FLAGS_EN
    chk("rst_flags", 32'(flags), 32'd0);
`endif
  endtask

  logic [31:0] vec_a [16] = '{32'h3F800000, 32'h3F800000, 32'h4B800000, 32'h00000000,
                              32'h7F7FFFFF, 32'h7F800000, 32'h3FC00000, 32'hC0400000,
                              32'h7FC00001, 32'hFF800000, 32'h80000000, 32'h80000000,
                              32'h3F800000, 32'h00C00000, 32'h4C000000, 32'h00000001};
  logic [31:0] vec_b [16] = '{32'h3F800000, 32'hBF400000, 32'h3F800000, 32'h40490FDB,
                              32'h7F7FFFFF, 32'hFF800000, 32'h40200000, 32'h3F800000,
                              32'h3F800000, 32'h40A00000, 32'h80000000, 32'h00000000,
                              32'hBF800000, 32'h80800000, 32'h3F800000, 32'h3F800000};
  int          vec_h [16] = '{0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0};

  initial begin
    logic [31:0] s; int l; logic o;
    // Pin the model with hand-computed results.
    fp_model(32'h3F800000, 32'h3F800000, s, l, o);
    chk("pin_1p1_sum", s, 32'h40000000); chk("pin_1p1_lat", 32'(l), 32'd4);
    fp_model(32'h3F800000, 32'hBF400000, s, l, o);
    chk("pin_1m075_sum", s, 32'h3E800000); chk("pin_1m075_lat", 32'(l), 32'd6);
    fp_model(32'h4B800000, 32'h3F800000, s, l, o);
    chk("pin_trunc_sum", s, 32'h4B800000);
    fp_model(32'h00000000, 32'h40490FDB, s, l, o);
    chk("pin_zero_sum", s, 32'h40490FDB); chk("pin_zero_lat", 32'(l), 32'd1);
    fp_model(32'h7F7FFFFF, 32'h7F7FFFFF, s, l, o);
    chk("pin_ovf_sum", s, 32'h7F800000); chk("pin_ovf_flag", 32'(o), 32'd1);
    fp_model(32'h7F800000, 32'hFF800000, s, l, o);
    chk("pin_nan_sum", s, 32'h7FC00000);

    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;
    #1;
    chk("rst_release_in_ready", 32'(in_ready), 32'd1);
    last_sum = 32'd0;
    in_reset = 1'b0;

    for (int i = 0; i < 16; i++) do_op(vec_a[i], vec_b[i], vec_h[i]);

    // Reset while the 1 + -0.75 operation is normalising.
    start_op(32'h3F800000, 32'hBF400000);
    repeat (3) begin @(posedge clk); #1; end
    in_reset = 1'b1;
    pending = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state();
    rst = 1'b0;
    last_sum = 32'd0;
    #1;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    in_reset = 1'b0;
    do_op(32'h3F800000, 32'hBF400000, 0);
    do_op(32'h3F800000, 32'h3F800000, 0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
